// File: rtl/mux7_rr_arbiter.sv
// mux7_rr_arbiter: round-robin arbiter driving a shared 7:1 single-bit mux with registered output.
// Define MUX7_ARB_TIMEOUT_EN to force-release an owner after HOLD_MAX consecutive grant cycles.
module mux7_rr_arbiter #(
  parameter int HOLD_MAX = 15,
  parameter int CNT_W = 4
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic [6:0] req,
  input  logic [6:0] data_in,
  output logic [6:0] grant,
  output logic [2:0] mux_sel,
  output logic       data_out,
  output logic       busy,
  output logic       timeout
);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t state, state_nx;
  logic [6:0] grant_nx;
  logic [2:0] sel_nx, rr_ptr, rr_nx, pick, idx;
  logic [3:0] sum;
  logic found, dout_nx, busy_nx, rel;
  if (2**CNT_W <= HOLD_MAX) begin : g_cfg
    $error("CNT_W too narrow for HOLD_MAX");
  end
  // first requester at or after rr_ptr, wrapping 6 -> 0
  always_comb begin
    pick = '0;
    found = 1'b0;
    sum = '0;
    idx = '0;
    for (int k = 0; k < 7; k++) begin
      sum = {1'b0, rr_ptr} + 4'(k);
      idx = sum > 4'd6 ? 3'(sum - 4'd7) : sum[2:0];
      if (!found && req[idx]) begin
        pick = idx;
        found = 1'b1;
      end
    end
  end
`ifdef MUX7_ARB_TIMEOUT_EN
  logic [CNT_W-1:0] hold_cnt, hold_nx;
  logic to_nx;
  assign rel = !req[mux_sel] || hold_cnt == CNT_W'(HOLD_MAX);
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) begin
      hold_cnt <= '0;
      timeout <= 1'b0;
    end else begin
      hold_cnt <= hold_nx;
      timeout <= to_nx;
    end
  // a voluntary drop on the expiry edge wins, so timeout only pulses if the owner still wants the mux
  always_comb begin
    hold_nx = '0;
    to_nx = 1'b0;
    if (state == IDLE) hold_nx = found ? CNT_W'(1) : '0;
    else if (!rel) hold_nx = hold_cnt + 1'b1;
    else to_nx = req[mux_sel];
  end
`else
  assign rel = !req[mux_sel];
  assign timeout = 1'b0;
`endif
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) begin
      state <= IDLE;
      grant <= '0;
      mux_sel <= 3'b111;
      data_out <= 1'b0;
      busy <= 1'b0;
      rr_ptr <= '0;
    end else begin
      state <= state_nx;
      grant <= grant_nx;
      mux_sel <= sel_nx;
      data_out <= dout_nx;
      busy <= busy_nx;
      rr_ptr <= rr_nx;
    end
  always_comb begin
    state_nx = state;
    grant_nx = grant;
    sel_nx = mux_sel;
    rr_nx = rr_ptr;
    dout_nx = data_out;
    busy_nx = busy;
    if (state == IDLE) begin
      if (found) begin
        state_nx = GRANT;
        grant_nx = 7'd1 << pick;
        sel_nx = pick;
        busy_nx = 1'b1;
      end
    end else if (rel) begin
      state_nx = IDLE;
      grant_nx = '0;
      sel_nx = 3'b111;
      dout_nx = 1'b0;
      busy_nx = 1'b0;
      rr_nx = mux_sel == 3'd6 ? 3'd0 : mux_sel + 3'd1;
    end else dout_nx = data_in[mux_sel];
  end
endmodule

// File: tb/tb_mux7_rr_arbiter.sv
// tb_mux7_rr_arbiter: directed self-checking bench for mux7_rr_arbiter.
module tb_mux7_rr_arbiter;
  logic clock = 1'b0;
  logic resetn;
  logic [6:0] req, data_in, grant;
  logic [2:0] mux_sel;
  logic data_out, busy, timeout;
  logic [12:0] obs, want;
  int cmp = 0, err = 0;
  localparam logic [12:0] IDLE_O = {7'd0, 3'd7, 3'd0};
  assign obs = {grant, mux_sel, data_out, busy, timeout};
  always #5 clock = ~clock;
  mux7_rr_arbiter dut (
    .clock(clock), .resetn(resetn), .req(req), .data_in(data_in),
    .grant(grant), .mux_sel(mux_sel), .data_out(data_out), .busy(busy), .timeout(timeout)
  );
  task automatic tick;
    @(posedge clock);
    #1;
  endtask
  task automatic restart;
    resetn = 1'b0;
    req = '0;
    data_in = '0;
    #3;
    resetn = 1'b1;
    tick;
  endtask
  task automatic test_reset;
    resetn = 1'b1;
    req = '0;
    data_in = '0;
    #1 resetn = 1'b0;
    #1 want = IDLE_O;
    cmp++; if (obs !== want) begin err++; $display("FAIL reset_init: got %b exp %b", obs, want); end
    tick;
    tick;
    cmp++; if (obs !== want) begin err++; $display("FAIL reset_hold: got %b exp %b", obs, want); end
    resetn = 1'b1;
    req = 7'b0001000;
    data_in = 7'b0001000;
    tick;
    want = {7'b0001000, 3'd3, 3'b010};
    cmp++; if (obs !== want) begin err++; $display("FAIL reset_grant3: got %b exp %b", obs, want); end
    tick;
    want = {7'b0001000, 3'd3, 3'b110};
    cmp++; if (obs !== want) begin err++; $display("FAIL reset_data3: got %b exp %b", obs, want); end
    #2 resetn = 1'b0;
    #1 want = IDLE_O;
    cmp++; if (obs !== want) begin err++; $display("FAIL reset_async: got %b exp %b", obs, want); end
    req = '0;
    data_in = '0;
    tick;
    resetn = 1'b1;
    tick;
    cmp++; if (obs !== want) begin err++; $display("FAIL reset_release: got %b exp %b", obs, want); end
  endtask
  task automatic test_single;
    logic [3:0] pat = 4'b1101;
    req = 7'b0000100;
    tick;
    want = {7'b0000100, 3'd2, 3'b010};
    cmp++; if (obs !== want) begin err++; $display("FAIL single_grant: got %b exp %b", obs, want); end
    for (int j = 0; j < 4; j++) begin
      data_in = pat[j] ? 7'b0000100 : 7'b1111011;
      tick;
      want = {7'b0000100, 3'd2, pat[j], 2'b10};
      cmp++; if (obs !== want) begin err++; $display("FAIL single_data[%0d]: got %b exp %b", j, obs, want); end
    end
    req = '0;
    data_in = '0;
    tick;
    want = IDLE_O;
    cmp++; if (obs !== want) begin err++; $display("FAIL single_drop: got %b exp %b", obs, want); end
    req = 7'b0001100;
    tick;
    want = {7'b0001000, 3'd3, 3'b010};
    cmp++; if (obs !== want) begin err++; $display("FAIL single_rrptr3: got %b exp %b", obs, want); end
    req = '0;
    tick;
  endtask
  task automatic test_rotation;
    logic [2:0] e;
    restart;
    req = 7'h7F;
    for (int n = 0; n < 8; n++) begin
      e = 3'(n % 7);
      tick;
      want = {7'(7'd1 << e), e, 3'b010};
      cmp++; if (obs !== want) begin err++; $display("FAIL rot_grant[%0d]: got %b exp %b", n, obs, want); end
      tick;
      cmp++; if (obs !== want) begin err++; $display("FAIL rot_hold[%0d]: got %b exp %b", n, obs, want); end
      req[e] = 1'b0;
      tick;
      want = IDLE_O;
      cmp++; if (obs !== want) begin err++; $display("FAIL rot_idle[%0d]: got %b exp %b", n, obs, want); end
      req[e] = 1'b1;
    end
    req = '0;
    tick;
  endtask
  task automatic test_wrap;
    restart;
    req = 7'b0100000;
    tick;
    req = '0;
    tick;
    req = 7'b1000001;
    tick;
    want = {7'b1000000, 3'd6, 3'b010};
    cmp++; if (obs !== want) begin err++; $display("FAIL wrap_grant6: got %b exp %b", obs, want); end
    req = 7'b0000001;
    tick;
    want = IDLE_O;
    cmp++; if (obs !== want) begin err++; $display("FAIL wrap_release6: got %b exp %b", obs, want); end
    tick;
    want = {7'b0000001, 3'd0, 3'b010};
    cmp++; if (obs !== want) begin err++; $display("FAIL wrap_grant0: got %b exp %b", obs, want); end
    req = '0;
    tick;
    want = IDLE_O;
    cmp++; if (obs !== want) begin err++; $display("FAIL wrap_idle: got %b exp %b", obs, want); end
  endtask
  task automatic test_contention;
    restart;
    data_in = 7'b0010000;
    req = 7'b0010000;
    tick;
    want = {7'b0010000, 3'd4, 3'b010};
    cmp++; if (obs !== want) begin err++; $display("FAIL cont_grant4: got %b exp %b", obs, want); end
    for (int j = 0; j < 6; j++) begin
      req[1] = ~req[1];
      tick;
      want = {7'b0010000, 3'd4, 3'b110};
      cmp++; if (obs !== want) begin err++; $display("FAIL cont_hold[%0d]: got %b exp %b", j, obs, want); end
    end
    req = '0;
    data_in = '0;
    tick;
    want = IDLE_O;
    cmp++; if (obs !== want) begin err++; $display("FAIL cont_release: got %b exp %b", obs, want); end
  endtask
  task automatic test_timeout;
    restart;
    req = 7'b0100000;
`ifdef MUX7_ARB_TIMEOUT_EN
    want = {7'b0100000, 3'd5, 3'b010};
    for (int c = 1; c <= 15; c++) begin
      tick;
      cmp++; if (obs !== want) begin err++; $display("FAIL to_hold[%0d]: got %b exp %b", c, obs, want); end
    end
    tick;
    want = {7'd0, 3'd7, 3'b001};
    cmp++; if (obs !== want) begin err++; $display("FAIL to_pulse: got %b exp %b", obs, want); end
    tick;
    want = {7'b0100000, 3'd5, 3'b010};
    cmp++; if (obs !== want) begin err++; $display("FAIL to_regrant: got %b exp %b", obs, want); end
    tick;
    cmp++; if (obs !== want) begin err++; $display("FAIL to_pulse_gone: got %b exp %b", obs, want); end
`else
    want = {7'b0100000, 3'd5, 3'b010};
    for (int c = 0; c < 120; c++) begin
      tick;
      cmp++; if (obs !== want) begin err++; $display("FAIL hold_forever[%0d]: got %b exp %b", c, obs, want); end
    end
`endif
    req = '0;
    tick;
    want = IDLE_O;
    cmp++; if (obs !== want) begin err++; $display("FAIL to_release: got %b exp %b", obs, want); end
  endtask
  initial begin
    test_reset;
    test_single;
    test_rotation;
    test_wrap;
    test_contention;
    test_timeout;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
    $finish;
  end
endmodule
